// File: rtl/cdb_arbiter.sv
// Purpose : shares the single ROB result-write port among ALU (0), LSU (1) and BRU (2)
//           through one-entry holding slots and a round-robin grant into a registered CDB.
// Latency : source fire in cycle N -> cdb_en in cycle N+2; 1 result/cycle total.
// Backpres: src_ready = !flush && (slot empty || slot granted this cycle); sources hold until fired.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   flush                   synchronous discard of slots and CDB output
//   {alu,lsu,bru}_en/_data/_tag   result offer from each execution unit
//   {alu,lsu,bru}_ready     slot can accept this cycle
//   cdb_en/_data/_tag/_src  registered broadcast to the ROB (src = granted unit index)
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_en,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [TAG_W-1:0]  alu_tag,
  output logic              alu_ready,
  input  logic              lsu_en,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic [TAG_W-1:0]  lsu_tag,
  output logic              lsu_ready,
  input  logic              bru_en,
  input  logic [DATA_W-1:0] bru_data,
  input  logic [TAG_W-1:0]  bru_tag,
  output logic              bru_ready,
  output logic              cdb_en,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [1:0]        cdb_src
);

  // Gather the three sources into indexable form.
  logic [2:0]        src_en;
  logic [DATA_W-1:0] src_data [3];
  logic [TAG_W-1:0]  src_tag  [3];

  assign src_en = {bru_en, lsu_en, alu_en};

  always_comb begin
    src_data[0] = alu_data;
    src_data[1] = lsu_data;
    src_data[2] = bru_data;
    src_tag[0]  = alu_tag;
    src_tag[1]  = lsu_tag;
    src_tag[2]  = bru_tag;
  end

  // Holding slots and round-robin pointer (index of the last grant).
  logic [2:0]        slot_v;
  logic [DATA_W-1:0] slot_data [3];
  logic [TAG_W-1:0]  slot_tag  [3];
  logic [1:0]        rr;

  logic [1:0] p0, p1, p2;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic [2:0] grant;
  logic [2:0] ready;
  logic [2:0] fire;
  logic [2:0] write;

  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order rr+1, rr+2, rr (mod 3); first valid slot wins. Flush suppresses the grant.
  always_comb begin
    p0      = rr_next(rr);
    p1      = rr_next(p0);
    p2      = rr_next(p1);
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    if (slot_v[p0]) begin
      gnt_vld = 1'b1;
      gnt_idx = p0;
    end else if (slot_v[p1]) begin
      gnt_vld = 1'b1;
      gnt_idx = p1;
    end else if (slot_v[p2]) begin
      gnt_vld = 1'b1;
      gnt_idx = p2;
    end
    if (flush) begin
      gnt_vld = 1'b0;
    end
    grant = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
  end

  // A granted slot can take a new entry on the same edge it drains, so a single
  // streaming source never sees a bubble.
  always_comb begin
    ready = flush ? 3'b000 : (~slot_v | grant);
    fire  = src_en & ready;
    for (int i = 0; i < 3; i++) begin
      // TAG_FREE results are handshaken but dropped so they never reach the ROB.
      write[i] = fire[i] && (src_tag[i] != TAG_FREE);
    end
  end

  assign alu_ready = ready[0];
  assign lsu_ready = ready[1];
  assign bru_ready = ready[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        slot_data[i] <= '0;
        slot_tag[i]  <= TAG_FREE;
      end
    end else begin
      if (flush) begin
        slot_v <= 3'b000;
      end else begin
        slot_v <= write | (slot_v & ~grant);
      end
      for (int i = 0; i < 3; i++) begin
        if (write[i]) begin
          slot_data[i] <= src_data[i];
          slot_tag[i]  <= src_tag[i];
        end
      end
    end
  end

  // Registered broadcast; payload holds its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_en   <= 1'b0;
      cdb_data <= '0;
      cdb_tag  <= TAG_FREE;
      cdb_src  <= 2'd0;
      rr       <= 2'd2;
    end else if (flush) begin
      cdb_en <= 1'b0;
    end else if (gnt_vld) begin
      cdb_en   <= 1'b1;
      cdb_data <= slot_data[gnt_idx];
      cdb_tag  <= slot_tag[gnt_idx];
      cdb_src  <= gnt_idx;
      rr       <= gnt_idx;
    end else begin
      cdb_en <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single ROB result-write port (en/data/tag) among three execution units: ALU (src 0), LSU (src 1) and branch unit (src 2).
- Each source has a one-entry holding slot.
- A round-robin arbiter grants at most one slot per cycle into a registered common-data-bus output, which drives the ROB result inputs.
- Sits between the EX stage units and the ROB; a synchronous flush discards in-flight results on redirect.

Parameters:
- DATA_W, 32, result data width.
- TAG_W, 4, ROB tag width; the low 3 bits index the ROB.
- TAG_FREE, 4'b1000, reserved "no tag" value that is never broadcast.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered and output results.
- alu_en  in  1  ALU result valid.
- alu_data  in  DATA_W  ALU result.
- alu_tag  in  TAG_W  ALU ROB tag.
- alu_ready  out  1  ALU slot can accept this cycle.
- lsu_en / lsu_data / lsu_tag / lsu_ready: same as ALU, for the LSU.
- bru_en / bru_data / bru_tag / bru_ready: same as ALU, for the branch unit.
- cdb_en  out  1  broadcast valid; connects to the ROB result enable.
- cdb_data  out  DATA_W  broadcast data.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_src  out  2  granted source index (0/1/2), for debug and forwarding.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Slot valid bits clear.
  - cdb_en=0, cdb_data=0, cdb_tag=TAG_FREE, cdb_src=0.
  - Round-robin last-grant pointer rr=2, so ALU has priority on the first arbitration.
  - All readys follow their combinational definition; with empty slots they are high once rst_n rises.
- Acceptance:
  - src_ready = !flush && (!slot_v[i] || grant[i]).
  - A source fires when src_en && src_ready; data and tag are captured into the slot at that edge.
  - A source must hold en/data/tag stable until it fires.
- Tag filter: a fire with tag==TAG_FREE is accepted (ready honoured) but not written to the slot, so it is never broadcast.
- Arbitration (combinational, from slot state only):
  - Search order is rr+1, rr+2, rr+3 mod 3; the first valid slot wins.
  - At most one grant per cycle.
  - When a grant occurs, rr <= granted index at the edge; otherwise rr holds.
- Output register, at each edge:
  - With a grant: cdb_en<=1, cdb_data/cdb_tag <= slot contents, cdb_src <= index, and the granted slot clears unless refilled the same edge.
  - Without a grant: cdb_en<=0, and data/tag/src hold their last values.
- Latency: source fires in cycle N -> earliest cdb_en in cycle N+2.
  - Throughput is 1 result per cycle total.
  - A single active source sustains 1 per cycle, since it refills on the grant edge.
- Same-cycle fill and grant of one slot: the new entry replaces the granted one, with no bubble.
- Flush (synchronous, highest priority):
  - All slot_v clear, cdb_en<=0, no grant is taken that cycle, rr unchanged.
  - All readys are 0 during flush, so same-cycle source fires are refused.
  - The cycle after flush, slots are empty and readys are high.
- rst_n asserted mid-operation drops all slots and the output immediately; no partial broadcast survives.
- Fairness: with all three sources continuously valid, grants rotate 0,1,2,0,…; each source waits at most 2 arbitration cycles once its slot is valid.
- cdb_en is high for exactly one cycle per accepted non-TAG_FREE result; no result is duplicated or dropped except by flush.

Test Plan:
1. Single ALU result:
   - After reset, alu_en=1, data=0x1234, tag=3 in cycle 0; alu_ready=1.
   - Cycle 2: cdb_en=1, data=0x1234, tag=3, src=0.
   - Cycle 3: cdb_en=0.
2. Three-way contention:
   - All sources fire in cycle 0 (ALU tag 1, LSU tag 2, BRU tag 4).
   - cdb tags are 1, 2, 4 in cycles 2, 3, 4, with src 0, 1, 2.
   - lsu_ready=0 during cycle 1 and bru_ready=0 during cycles 1–2.
3. Back-to-back streaming: ALU fires every cycle for 5 cycles with tags 0–4 while the others are idle -> cdb_en high in cycles 2–6 with tags 0–4 in order, and alu_ready stays 1 throughout.
4. Rotation under saturation: all sources hold en=1 continuously for 9 cycles -> cdb_src sequence 0,1,2,0,1,2,…; no source is granted twice before the others are granted once.
5. Flush:
   - LSU and BRU slots are valid and flush=1 in cycle 1 -> cdb_en=0 in cycle 2 and no broadcast of those tags afterwards.
   - alu_en=1 with tag 5 during the flush cycle is refused (alu_ready=0).
6. TAG_FREE and async reset:
   - bru_tag=4'b1000 fires -> no cdb_en ever results.
   - rst_n pulled low mid-burst -> cdb_en=0 and cdb_tag=TAG_FREE immediately, without waiting for a clock edge.
